// File: rtl/circuit_pair_checker.sv
// Evaluates a canonical-SOP and a minimised circuit for the same 4-input F, registers both and tracks mismatches/coverage.
// Latency: 1 cycle from in_valid to out_valid. Optional fault_en port under CIRCUIT_PAIR_FAULT_INJECT_EN.
// Backpressure: none; one vector is accepted every cycle in_valid is high.

// Canonical sum of minterms 1,3,5,7,9,11,12,13 built from gate primitives.
module my_first_circuit (
    output logic out,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d
);
    logic na, nb, nc, nd;
    logic m1, m3, m5, m7, m9, m11, m12, m13;

    not g_na (na, a);
    not g_nb (nb, b);
    not g_nc (nc, c);
    not g_nd (nd, d);

    and g_m1  (m1,  na, nb, nc, d);
    and g_m3  (m3,  na, nb, c,  d);
    and g_m5  (m5,  na, b,  nc, d);
    and g_m7  (m7,  na, b,  c,  d);
    and g_m9  (m9,  a,  nb, nc, d);
    and g_m11 (m11, a,  nb, c,  d);
    and g_m12 (m12, a,  b,  nc, nd);
    and g_m13 (m13, a,  b,  nc, d);

    or  g_out (out, m1, m3, m5, m7, m9, m11, m12, m13);
endmodule

// Minimised form: F = a'd + b'd + abc'.
module my_second_circuit (
    output logic out,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d
);
    assign out = (~a & d) | (~b & d) | (a & b & ~c);
endmodule

module circuit_pair_checker #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CIRCUIT_PAIR_FAULT_INJECT_EN
    input  logic             fault_en,
`endif
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    input  logic             in_d,
    output logic             out_valid,
    output logic             out_1,
    output logic             out_2,
    output logic             mismatch,
    output logic             mismatch_seen,
    output logic [15:0]      coverage,
    output logic             all_covered,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] mismatch_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0] idx;
    logic       f1, f2_raw, f2, diff;
    logic [1:0] rst_pipe;
    logic       rst_int_n;

    assign idx = {in_a, in_b, in_c, in_d};

    my_first_circuit  u_first  (.out(f1),     .a(in_a), .b(in_b), .c(in_c), .d(in_d));
    my_second_circuit u_second (.out(f2_raw), .a(in_a), .b(in_b), .c(in_c), .d(in_d));

`ifdef CIRCUIT_PAIR_FAULT_INJECT_EN
    assign f2 = f2_raw ^ (fault_en & (idx == 4'hF));
`else
    assign f2 = f2_raw;
`endif

    assign diff = f1 ^ f2;

    // Reset asserts immediately but releases two edges later, aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_int_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            out_valid <= 1'b0;
            out_1     <= 1'b0;
            out_2     <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_1    <= f1;
                out_2    <= f2;
                mismatch <= diff;
            end
        end
    end

    // Clear takes priority over a coincident vector: results register, stats do not.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vec_count      <= '0;
            mismatch_count <= '0;
            coverage       <= '0;
            mismatch_seen  <= 1'b0;
        end else if (clear) begin
            vec_count      <= '0;
            mismatch_count <= '0;
            coverage       <= '0;
            mismatch_seen  <= 1'b0;
        end else if (in_valid) begin
            if (vec_count != CNT_MAX) vec_count <= vec_count + CNT_W'(1);
            coverage <= coverage | (16'd1 << idx);
            if (diff) begin
                mismatch_seen <= 1'b1;
                if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + CNT_W'(1);
            end
        end
    end

    assign all_covered = (coverage == 16'hFFFF);
endmodule

// File: tb/tb_circuit_pair_checker.sv
// Directed bench for circuit_pair_checker; a second instance with CNT_W=4 exercises saturation.
module tb_circuit_pair_checker;
    localparam logic [15:0] F_TT = 16'h3AAA;   // minterms 1,3,5,7,9,11,12,13

    typedef struct packed {
        logic o1;
        logic o2;
        logic mm;
    } exp_t;

    logic        clk, rst_n, clear, in_valid, in_a, in_b, in_c, in_d, fault_on;
    logic        out_valid, out_1, out_2, mismatch, mismatch_seen, all_covered;
    logic [15:0] coverage;
    logic [7:0]  vec_count, mismatch_count;
    logic        out_valid4, out_14, out_24, mismatch4, mismatch_seen4, all_covered4;
    logic [15:0] coverage4;
    logic [3:0]  vec_count4, mismatch_count4;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t held;
    int   m_vec, m_mm, m_vec4, m_mm4;
    logic [15:0] m_cov;
    logic        m_seen;

    circuit_pair_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef CIRCUIT_PAIR_FAULT_INJECT_EN
        .fault_en(fault_on),
`endif
        .clear(clear), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_1(out_1), .out_2(out_2), .mismatch(mismatch),
        .mismatch_seen(mismatch_seen), .coverage(coverage), .all_covered(all_covered),
        .vec_count(vec_count), .mismatch_count(mismatch_count)
    );

    circuit_pair_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
`ifdef CIRCUIT_PAIR_FAULT_INJECT_EN
        .fault_en(fault_on),
`endif
        .clear(clear), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid4), .out_1(out_14), .out_2(out_24), .mismatch(mismatch4),
        .mismatch_seen(mismatch_seen4), .coverage(coverage4), .all_covered(all_covered4),
        .vec_count(vec_count4), .mismatch_count(mismatch_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_vec = 0; m_mm = 0; m_vec4 = 0; m_mm4 = 0;
        m_cov = '0; m_seen = 1'b0;
    endtask

    task automatic check_stats();
        chk("vec_count", 32'(vec_count), 32'(m_vec));
        chk("mismatch_count", 32'(mismatch_count), 32'(m_mm));
        chk("coverage", 32'(coverage), 32'(m_cov));
        chk("all_covered", 32'(all_covered), 32'(m_cov == 16'hFFFF));
        chk("mismatch_seen", 32'(mismatch_seen), 32'(m_seen));
        chk("vec_count_w4", 32'(vec_count4), 32'(m_vec4));
        chk("mismatch_count_w4", 32'(mismatch_count4), 32'(m_mm4));
    endtask

    // One cycle: drive at negedge, push expectation, check 1ns after the sampling edge.
    task automatic step(input logic [3:0] idx, input logic v, input logic clr);
        exp_t e, got;
        logic f, f2;
        @(negedge clk);
        in_valid = v; clear = clr;
        {in_a, in_b, in_c, in_d} = idx;
        f  = F_TT[idx];
        f2 = f ^ (fault_on & (idx == 4'hF));
        if (v) begin
            e.o1 = f; e.o2 = f2; e.mm = f ^ f2;
            q.push_back(e);
        end
        if (clr) model_reset();
        else if (v) begin
            if (m_vec < 255) m_vec++;
            if (m_vec4 < 15) m_vec4++;
            m_cov[idx] = 1'b1;
            if (f != f2) begin
                m_seen = 1'b1;
                if (m_mm < 255) m_mm++;
                if (m_mm4 < 15) m_mm4++;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(v));
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("scoreboard_underflow", 32'(q.size()), 32'd1);
            end else begin
                got  = q.pop_front();
                held = got;
            end
        end
        chk("out_1", 32'(out_1), 32'(held.o1));
        chk("out_2", 32'(out_2), 32'(held.o2));
        chk("mismatch", 32'(mismatch), 32'(held.mm));
        check_stats();
        in_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic reset_mid_cycle();
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        held = '0;
        model_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_1", 32'(out_1), 32'd0);
        chk("rst_out_2", 32'(out_2), 32'd0);
        chk("rst_mismatch", 32'(mismatch), 32'd0);
        check_stats();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; fault_on = 1'b0;
        {in_a, in_b, in_c, in_d} = 4'h0;
        held = '0;
        model_reset();
        @(posedge clk);
        reset_mid_cycle();

        for (int i = 0; i < 16; i++) step(4'(i), 1'b1, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        chk("sweep_vec_count", 32'(vec_count), 32'd16);
        chk("sweep_all_covered", 32'(all_covered), 32'd1);
        chk("sweep_vec_count_w4_sat", 32'(vec_count4), 32'd15);

        reset_mid_cycle();

        step(4'h5, 1'b1, 1'b0);
        step(4'h0, 1'b0, 1'b0);
        chk("idle_hold_out_1", 32'(out_1), 32'd1);
        step(4'h5, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        chk("gaps_vec_count", 32'(vec_count), 32'd3);
        chk("gaps_coverage", 32'(coverage), 32'h0021);

        step(4'h3, 1'b1, 1'b1);
        chk("clear_out_1", 32'(out_1), 32'd1);
        chk("clear_vec_count", 32'(vec_count), 32'd0);
        step(4'h0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) step(4'(i % 16), 1'b1, 1'b0);
        chk("sat_vec_count_w4", 32'(vec_count4), 32'd15);
        chk("sat_vec_count_w8", 32'(vec_count), 32'd20);

`ifdef CIRCUIT_PAIR_FAULT_INJECT_EN
        fault_on = 1'b1;
        step(4'hF, 1'b1, 1'b0);
        chk("fault_mismatch", 32'(mismatch), 32'd1);
        chk("fault_mismatch_count", 32'(mismatch_count), 32'd1);
        fault_on = 1'b0;
        step(4'h0, 1'b1, 1'b0);
        chk("fault_seen_sticky", 32'(mismatch_seen), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
